if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction fetch stage of a 5-stage in-order pipeline.
//
// Issues one instruction SRAM read per cycle whenever the stage can accept a
// new word. The word comes back the following cycle. A one-entry buffer keeps
// that word if decode stalls, because the SRAM output is not held once the
// read enable drops. A redirect from decode discards the current instruction
// and the buffer, and fetches the target in the same cycle.
//
// Ports
//   clk              sole clock, rising edge
//   resetn           synchronous active-low reset
//   ds_allowin       decode can accept an instruction this cycle
//   br_taken         one-cycle redirect request from decode
//   br_target        redirect address, valid with br_taken
//   fs_to_ds_valid   fetch offers an instruction to decode
//   fs_to_ds_bus     {fs_pc, fs_inst}
//   inst_sram_en     instruction SRAM read enable
//   inst_sram_we     byte write enables, always zero
//   inst_sram_addr   fetch address (nextpc)
//   inst_sram_wdata  write data, always zero
//   inst_sram_rdata  read data, valid the cycle after an enabled read
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  // Sequential next address wraps naturally modulo 2^32.
  assign seq_pc = fs_pc + 32'd4;
  assign nextpc = br_taken ? br_target : seq_pc;

  // A redirect always lets the stage accept, so the wrong-path word is dropped.
  assign fs_allowin = !fs_valid | ds_allowin | br_taken;

  assign inst_sram_en    = resetn & fs_allowin;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  // Once the SRAM output has moved on, the buffered copy is the real word.
  assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;

  // Gating with resetn keeps the offer low even in the reset cycle itself.
  assign fs_to_ds_valid = resetn & fs_valid & !br_taken;
  assign fs_to_ds_bus   = {fs_pc, fs_inst};

  // fs_pc starts one word before RESET_PC so that the first sequential
  // nextpc after reset lands exactly on RESET_PC.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC - 32'd4;
      buf_valid <= 1'b0;
      inst_buf  <= 32'h0;
    end else begin
      if (fs_allowin) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
      end

      // Capture the returning word on the first stalled cycle only; later
      // stalled cycles see garbage on rdata because no read was issued.
      if (fs_allowin) begin
        buf_valid <= 1'b0;
      end else if (fs_valid && !ds_allowin && !br_taken && !buf_valid) begin
        buf_valid <= 1'b1;
        inst_buf  <= inst_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
//
// An SRAM model returns a fixed hash of the address one cycle after an
// enabled read and random garbage otherwise. The reference model tracks only
// the architectural view: whether an instruction is held and its pc; the
// offered word must always equal the hash of that pc.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1C000000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = 32'h0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ds_allowin     (ds_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5} + 32'h0001_0203;
  endfunction

  // Synchronous-read SRAM; without an enabled read the output is garbage.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= memWord(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, checks combinational outputs against the
  // model before the edge, then advances the model across the edge.
  // When chk_addr is set the fetch address is also compared to a constant.
  task automatic applyStimulus(input logic rn, input logic ds, input logic br,
                               input logic [31:0] tgt, input bit chk_addr,
                               input logic [31:0] addr_const);
    logic        exp_en;
    logic        exp_ofr;
    logic [31:0] exp_addr;
    resetn = rn; ds_allowin = ds; br_taken = br; br_target = tgt;
    #3;
    exp_en   = rn && (!m_valid || ds || br);
    exp_ofr  = rn && m_valid && !br;
    exp_addr = br ? tgt : m_pc + 32'd4;
    checkOutput("sram_en", {63'd0, inst_sram_en}, {63'd0, exp_en});
    checkOutput("offer_valid", {63'd0, fs_to_ds_valid}, {63'd0, exp_ofr});
    checkOutput("sram_we", {60'd0, inst_sram_we}, 64'd0);
    checkOutput("sram_wdata", {32'd0, inst_sram_wdata}, 64'd0);
    if (exp_en)  checkOutput("sram_addr", {32'd0, inst_sram_addr}, {32'd0, exp_addr});
    if (exp_ofr) checkOutput("offer_bus", fs_to_ds_bus, {m_pc, memWord(m_pc)});
    if (chk_addr) checkOutput("addr_const", {32'd0, inst_sram_addr}, {32'd0, addr_const});
    @(posedge clk);
    #1;
    if (!rn) begin
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
    end else if (exp_en) begin
      m_valid = 1'b1;
      m_pc    = exp_addr;
    end
  endtask

  initial begin
    resetn = 1'b0; ds_allowin = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    @(posedge clk); #1;
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // Reset release with decode always ready.
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000000);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000004);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000008);

    // Stall three cycles at pc 1C000008, then resume.
    checkOutput("stall_pc", {32'd0, fs_to_ds_bus[63:32]}, {32'd0, 32'h1C000008});
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C00000C);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000010);

    // Redirect while fs holds 1C000010.
    applyStimulus(1, 1, 1, 32'h1C000100, 1, 32'h1C000100);
    checkOutput("redirect_pc", {32'd0, fs_to_ds_bus[63:32]}, {32'd0, 32'h1C000100});

    // Redirect during a stall with the buffer filled.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h1C000200, 1, 32'h1C000200);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000204);

    // One-cycle reset mid-stream, then refetch from RESET_PC.
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000000);
    applyStimulus(1, 1, 0, 0, 1, 32'h1C000004);

    // Address wrap-around at the top of memory.
    applyStimulus(1, 1, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC);
    applyStimulus(1, 1, 0, 0, 1, 32'h00000000);
    applyStimulus(1, 1, 0, 0, 1, 32'h00000004);

    // Randomized traffic with occasional stalls, redirects and resets.
    for (int i = 0; i < 400; i++) begin
      logic        r_rn;
      logic        r_ds;
      logic        r_br;
      logic [31:0] r_tgt;
      r_rn  = ($urandom_range(0, 63) != 0);
      r_ds  = ($urandom_range(0, 3) != 0);
      r_br  = ($urandom_range(0, 7) == 0);
      r_tgt = {16'h1C00, 14'($urandom), 2'b00};
      applyStimulus(r_rn, r_ds, r_br, r_tgt, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
